// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared control-flow types for fetch redirect sequencing.
// PC select codes and the redirect sequencer state.
package pc_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    next_pc        = 3'd0,
    branch_alu     = 3'd1,
    branch_pc_jump = 3'd2,
    trap_illegal   = 3'd3,
    xepc           = 3'd4,
    Z              = 3'd5
  } pcsrc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } redir_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage control-flow sequencer: selects PC source, enables
// and flushes, and replays redirects that arrive while frozen.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             START,
  input  logic             mem_mret,
  input  logic             mem_jalr,
  input  logic             mem_taken,
  input  logic             id_illegal,
  input  logic             load_use,
  output pcsrc_t           pcsrc,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             fsm_sel,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             pc_changed,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] trap_cnt,
  output logic             multi_err
);

  redir_state_t state, state_d, cur;
  pcsrc_t       pend_q, pend_d;
  pcsrc_t       ev_code;
  logic         ev_any;
  logic         multi_mem;

  always_comb begin
    ev_code = next_pc;
    if (mem_mret)
      ev_code = xepc;
    else if (mem_jalr)
      ev_code = branch_alu;
    else if (mem_taken)
      ev_code = branch_pc_jump;
    else if (id_illegal)
      ev_code = trap_illegal;
  end

  assign ev_any = (ev_code != next_pc);

  assign multi_mem = (mem_mret & mem_jalr) |
                     (mem_mret & mem_taken) |
                     (mem_jalr & mem_taken);

  // Outputs show IDLE values while reset is held.
  assign cur = RSTn ? state : IDLE;

  always_comb begin
    state_d     = cur;
    pend_d      = pend_q;
    pcsrc       = next_pc;
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    fsm_sel     = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    pc_changed  = 1'b0;
    unique case (cur)
      IDLE: begin
        fsm_sel = 1'b1;
        if (START)
          state_d = RUN;
      end
      RUN: begin
        if (EN) begin
          if (ev_any) begin
            pcsrc       = ev_code;
            pc_changed  = 1'b1;
            en_pc       = 1'b1;
            en_ifid     = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = (ev_code != trap_illegal);
          end else if (load_use) begin
            flush_idex = 1'b1;
          end else begin
            en_pc   = 1'b1;
            en_ifid = 1'b1;
          end
        end else if (ev_any) begin
          pend_d  = ev_code;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (EN) begin
          pcsrc       = pend_q;
          pc_changed  = 1'b1;
          en_pc       = 1'b1;
          en_ifid     = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = (pend_q != trap_illegal);
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      pend_q    <= next_pc;
      multi_err <= 1'b0;
    end else begin
      state  <= state_d;
      pend_q <= pend_d;
      if (multi_mem)
        multi_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (pc_changed),
    .cnt   (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_trap_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (pc_changed && (pcsrc == trap_illegal)),
    .cnt   (trap_cnt)
  );

endmodule
